// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record.
package regfile_pkg;
    localparam int REG_AW   = 4;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 16;
    localparam logic [REG_AW-1:0] PC_ADDR = 4'hF;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);
    localparam logic [PW:0] NW = (PW+1)'(N);

    logic [PW:0] cand;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= NW) cand = cand - NW;
            if (!found && req[cand[PW-1:0]]) begin
                found                 = 1'b1;
                gnt_idx               = cand[PW-1:0];
                gnt[cand[PW-1:0]]     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among writeback requesters, tracks
// pending writes in a scoreboard and diverts R15 writes to the PC port.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               alloc_valid,
    input  logic [AW-1:0]      alloc_addr,
    output logic               alloc_ready,
    output logic [NUM_REGS-1:0] busy,
    output logic               we3,
    output logic [AW-1:0]      wa3,
    output logic [DW-1:0]      wd3,
    output logic               pc_we,
    output logic [DW-1:0]      pc_wd
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       gnt_idx;
    logic [NREQ-1:0]     gnt;
    logic                xfer;
    wb_req_t             sel;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                we3_q, pc_we_q;
    logic [AW-1:0]       wa3_q;
    logic [DW-1:0]       wd3_q, pc_wd_q;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign sel.addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel.data  = req_data[int'(gnt_idx)*DW +: DW];

    assign alloc_ready = (alloc_addr == PC_ADDR) ? 1'b1 : ~busy_q[alloc_addr];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

        busy_d = busy_q;
        if (alloc_valid && alloc_ready && alloc_addr != PC_ADDR) busy_d[alloc_addr] = 1'b1;
        if (xfer) busy_d[sel.addr] = 1'b0;
        // The PC is never tracked.
        busy_d[PC_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            busy_q   <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            pc_we_q  <= 1'b0;
            pc_wd_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            we3_q    <= xfer && (sel.addr != PC_ADDR);
            pc_we_q  <= xfer && (sel.addr == PC_ADDR);
            if (xfer && sel.addr != PC_ADDR) begin
                wa3_q <= sel.addr;
                wd3_q <= sel.data;
            end
            if (xfer && sel.addr == PC_ADDR) pc_wd_q <= sel.data;
        end
    end

    assign busy  = busy_q;
    assign we3   = we3_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    assign pc_we = pc_we_q;
    assign pc_wd = pc_wd_q;
endmodule
